// File: rtl/leb128_pkg.sv
// Shared types and helpers for the LEB128 encoder family.
package leb128_pkg;

    localparam int unsigned CONT_BIT = 7;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Bytes needed for the worst-case encoding of a w-bit integer.
    function automatic int unsigned leb_maxb(input int unsigned w);
        return (w + 6) / 7;
    endfunction

endpackage

// File: rtl/leb128_chunk.sv
// One LEB128 step: low 7-bit chunk with continuation flag, termination test and remaining value.
module leb128_chunk
    import leb128_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         sgn,
    input  logic         at_cap,
    output logic [7:0]   chunk,
    output logic         last,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt   = '0;
        last  = 1'b0;
        chunk = 8'h00;
        if (sgn) begin
            nxt  = W'($signed(rem) >>> 7);
            // Stop once the remaining bits are pure sign extension of the chunk's bit 6.
            last = ((nxt == '0) && !rem[6]) || ((nxt == '1) && rem[6]) || at_cap;
        end else begin
            nxt  = rem >> 7;
            last = (nxt == '0) || at_cap;
        end
        chunk[6:0]      = rem[6:0];
        chunk[CONT_BIT] = ~last;
    end

endmodule

// File: rtl/leb128_stream_enc.sv
// Streaming LEB128 encoder: one W-bit word in, its ULEB128/SLEB128 bytes out one per cycle.
module leb128_stream_enc
    import leb128_pkg::*;
#(
    parameter int unsigned  W    = 32,
    localparam int unsigned MAXB = leb_maxb(W),
    localparam int unsigned LW   = $clog2(MAXB + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [LW-1:0] out_len
);

    state_t        state;
    logic [W-1:0]  rem;
    logic          sgn;
    logic [LW-1:0] idx;

    logic [7:0]    cbyte;
    logic          clast;
    logic [W-1:0]  cnxt;
    logic          at_cap;
    logic          byte_done;
    logic          word_take;

    assign at_cap = (idx == LW'(MAXB));

    leb128_chunk #(.W(W)) u_chunk (
        .rem    (rem),
        .sgn    (sgn),
        .at_cap (at_cap),
        .chunk  (cbyte),
        .last   (clast),
        .nxt    (cnxt)
    );

    // Presented byte is decoded from the held word; zero while idle.
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && clast;
    assign out_data  = out_valid ? cbyte : 8'h00;
    assign out_len   = out_valid ? idx : '0;

    assign byte_done = out_valid && out_ready;
    // Final-byte handoff lets the next word load without a bubble.
    assign in_ready  = (state == IDLE) || (byte_done && clast);
    assign word_take = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            sgn   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem   <= in_data;
                        sgn   <= in_signed;
                        idx   <= LW'(1);
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (byte_done) begin
                        if (!clast) begin
                            rem <= cnxt;
                            idx <= idx + LW'(1);
                        end else if (word_take) begin
                            rem <= in_data;
                            sgn <= in_signed;
                            idx <= LW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_stream_enc.sv
// Directed and randomized-backpressure bench for leb128_stream_enc (W=32 and W=64 instances).
module tb_leb128_stream_enc;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic [3:0] len;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_len;

    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] in_data64;
    logic        out_valid64;
    logic [7:0]  out_data64;
    logic        out_last64;
    logic [3:0]  out_len64;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    exp_t pend_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [2:0] prev_len;

    leb128_stream_enc #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_len   (out_len)
    );

    leb128_stream_enc #(.W(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_data   (in_data64),
        .in_signed (1'b0),
        .out_valid (out_valid64),
        .out_ready (1'b1),
        .out_data  (out_data64),
        .out_last  (out_last64),
        .out_len   (out_len64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference encoder on 64-bit signed arithmetic.
    task automatic ref_enc(input logic [31:0] v, input logic s);
        longint x;
        logic [7:0] b;
        logic done;
        int n;
        x = s ? longint'($signed(v)) : longint'(v);
        n = 0;
        done = 1'b0;
        pend_q.delete();
        while (!done) begin
            b = {1'b0, x[6:0]};
            x = x >>> 7;
            n++;
            done = s ? (((x == 0) && !b[6]) || ((x == -1) && b[6])) : (x == 0);
            pend_q.push_back('{b: {~done, b[6:0]}, last: done, len: 4'(n)});
        end
    endtask

    // One cycle: apply inputs at negedge, check presented outputs against the expectation queue.
    task automatic step(input logic iv, input logic [31:0] d, input logic s, input logic ordy,
                        output logic acc);
        logic was_empty;
        logic xfer_last;
        exp_t f;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_signed = s;
        out_ready = ordy;
        #1;
        was_empty = (exp_q.size() == 0);
        if (stall_prev) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
            check("hold_len", out_len, prev_len);
        end
        check("out_valid", out_valid, !was_empty);
        xfer_last = 1'b0;
        if (!was_empty) begin
            f = exp_q[0];
            check("out_data", out_data, f.b);
            check("out_last", out_last, f.last);
            if (f.last) check("out_len", out_len, f.len);
            if (ordy) begin
                void'(exp_q.pop_front());
                xfer_last = f.last;
            end
        end
        check("in_ready", in_ready, was_empty || xfer_last);
        acc = iv && (was_empty || xfer_last);
        if (acc) begin
            while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        end
        stall_prev = !was_empty && !ordy;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_len   = out_len;
    endtask

    task automatic drain();
        logic acc;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, acc);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // bytes[7:0] is the first byte on the wire.
    task automatic directed(input logic [31:0] v, input logic s, input logic [39:0] bytes, input int n);
        logic acc;
        int guard;
        pend_q.delete();
        for (int i = 0; i < n; i++)
            pend_q.push_back('{b: bytes[8*i +: 8], last: (i == n - 1), len: 4'(i + 1)});
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            step(1'b1, v, s, 1'b1, acc);
            guard++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        drain();
    endtask

    initial begin
        logic acc;
        logic [31:0] v;
        logic s;
        int guard;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_signed  = 1'b0;
        out_ready  = 1'b0;
        in_valid64 = 1'b0;
        in_data64  = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_len", out_len, 3'd0);
        rst = 1'b0;

        directed(32'd624485,     1'b0, 40'h00_00_26_8E_E5, 3);
        directed(-32'sd123456,   1'b1, 40'h00_00_78_BB_C0, 3);
        directed(32'd64,         1'b1, 40'h00_00_00_00_C0, 2);
        directed(32'hFFFF_FFFF,  1'b1, 40'h00_00_00_00_7F, 1);
        directed(-32'sd64,       1'b1, 40'h00_00_00_00_40, 1);
        directed(32'd0,          1'b0, 40'h00_00_00_00_00, 1);
        directed(32'd0,          1'b1, 40'h00_00_00_00_00, 1);
        directed(32'd128,        1'b0, 40'h00_00_00_01_80, 2);
        directed(32'hFFFF_FFFF,  1'b0, 40'h0F_FF_FF_FF_FF, 5);
        directed(32'h7FFF_FFFF,  1'b1, 40'h07_FF_FF_FF_FF, 5);
        directed(32'h8000_0000,  1'b1, 40'h78_80_80_80_80, 5);

        // Reset while the second byte of 0xFFFFFFFF is presented.
        pend_q.delete();
        for (int i = 0; i < 5; i++)
            pend_q.push_back('{b: (i == 4) ? 8'h0F : 8'hFF, last: (i == 4), len: 4'(i + 1)});
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("rst_mid_byte2", out_data, 8'hFF);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        #1;
        check("rst_next_out_valid", out_valid, 1'b0);
        check("rst_next_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        directed(32'd5, 1'b0, 40'h00_00_00_00_05, 1);

        // Mixed-mode words: first 30 with full throughput, then random backpressure.
        for (int w = 0; w < 100; w++) begin
            v = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (s && ($urandom_range(0, 1) == 1)) v = -v;
            ref_enc(v, s);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                if (w < 30) step(1'b1, v, s, 1'b1, acc);
                else step($urandom_range(0, 3) != 0, v, s, $urandom_range(0, 2) != 0, acc);
                guard++;
            end
            if (!acc) check("rand_accept_timeout", 64'(acc), 64'd1);
        end
        drain();

        // W=64: unsigned all-ones needs the full ten bytes.
        @(negedge clk);
        in_valid64 = 1'b1;
        in_data64  = '1;
        #1;
        check("w64_in_ready", in_ready64, 1'b1);
        @(negedge clk);
        in_valid64 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("w64_valid", out_valid64, 1'b1);
            check("w64_data", out_data64, (i == 9) ? 8'h01 : 8'hFF);
            check("w64_last", out_last64, (i == 9));
            if (i == 9) check("w64_len", out_len64, 4'd10);
            @(negedge clk);
        end
        #1;
        check("w64_idle", out_valid64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
